// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Purpose  : Request sequencer for a direct-mapped write-back cache.
//            It accepts one CPU word request at a time and latches its
//            tag/index/offset. It drives the cache lookup enables. On a
//            miss it writes back a dirty victim, refills the block from
//            memory, and then replays the lookup.
// Options  : CACHE_STATS_EN adds saturating hit/miss/write-back counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
  parameter int TAG_W    = 24,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cpu_valid,
  input  logic                              cpu_req_type,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] cpu_addr,
  output logic                              cpu_done,
  output logic                              cpu_busy,
  output logic [TAG_W-1:0]                  tag,
  output logic [INDEX_W-1:0]                index,
  output logic [OFFSET_W-1:0]               blk_offset,
  output logic                              req_type,
  output logic                              read_en_cache,
  output logic                              write_en_cache,
  output logic                              ready_mem,
  input  logic                              hit,
  input  logic                              dirty_bit,
  input  logic [TAG_W-1:0]                  victim_tag,
  output logic                              mem_rd_req,
  output logic                              mem_wr_req,
  output logic [TAG_W+INDEX_W-1:0]          mem_addr,
  input  logic                              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]                  hit_count,
  output logic [CNT_W-1:0]                  miss_count,
  output logic [CNT_W-1:0]                  wb_count
`endif
);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_COMPARE    = 2'd1;
  localparam logic [1:0] c_WRITE_BACK = 2'd2;
  localparam logic [1:0] c_ALLOCATE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [TAG_W-1:0]    wb_tag_q, wb_tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                req_type_q, req_type_d;
  logic                done_q, done_d;
  logic                accept;

  // A new request is taken only from IDLE, never in the done-pulse cycle.
  assign accept = (state_q == c_IDLE) && cpu_valid && !done_q;

  // Next-state and request-latch logic.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    wb_tag_d   = wb_tag_q;
    index_d    = index_q;
    offset_d   = offset_q;
    req_type_d = req_type_q;
    done_d     = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (accept) begin
          offset_d   = cpu_addr[OFFSET_W-1:0];
          index_d    = cpu_addr[OFFSET_W +: INDEX_W];
          tag_d      = cpu_addr[OFFSET_W+INDEX_W +: TAG_W];
          req_type_d = cpu_req_type;
          state_d    = c_COMPARE;
        end
      end
      c_COMPARE: begin
        if (hit) begin
          state_d = c_IDLE;
          done_d  = 1'b1;
        end else if (dirty_bit) begin
          // Capture the victim tag now; the cache line is overwritten later.
          wb_tag_d = victim_tag;
          state_d  = c_WRITE_BACK;
        end else begin
          state_d = c_ALLOCATE;
        end
      end
      c_WRITE_BACK: if (mem_ready) state_d = c_ALLOCATE;
      c_ALLOCATE:   if (mem_ready) state_d = c_COMPARE;
      default:      state_d = c_IDLE;
    endcase
  end

  // State and latched-request registers; reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_IDLE;
      tag_q      <= '0;
      wb_tag_q   <= '0;
      index_q    <= '0;
      offset_q   <= '0;
      req_type_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      wb_tag_q   <= wb_tag_d;
      index_q    <= index_d;
      offset_q   <= offset_d;
      req_type_q <= req_type_d;
      done_q     <= done_d;
    end
  end

  // Cache enables and memory handshake decode from the current state.
  always_comb begin
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    ready_mem      = 1'b0;
    mem_rd_req     = 1'b0;
    mem_wr_req     = 1'b0;
    mem_addr       = '0;
    case (state_q)
      c_COMPARE: begin
        read_en_cache  = 1'b1;
        write_en_cache = req_type_q;
      end
      c_WRITE_BACK: begin
        mem_wr_req = 1'b1;
        mem_addr   = {wb_tag_q, index_q};
      end
      c_ALLOCATE: begin
        mem_rd_req     = 1'b1;
        mem_addr       = {tag_q, index_q};
        // The refill is written in the same cycle that memory acknowledges.
        write_en_cache = mem_ready;
        ready_mem      = mem_ready;
      end
      default: ;
    endcase
  end

  assign cpu_done   = done_q;
  assign cpu_busy   = (state_q != c_IDLE) || done_q;
  assign tag        = tag_q;
  assign index      = index_q;
  assign blk_offset = offset_q;
  assign req_type   = req_type_q;

`ifdef CACHE_STATS_EN
  logic             replay_q, replay_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  // Saturating statistics; the hit after a refill is a replay and is not counted.
  always_comb begin
    replay_d   = replay_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (accept) replay_d = 1'b0;
    if (state_q == c_COMPARE) begin
      if (hit) begin
        if (!replay_q && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
      end else begin
        replay_d = 1'b1;
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
    if ((state_q == c_WRITE_BACK) && mem_ready && (wb_cnt_q != '1))
      wb_cnt_d = wb_cnt_q + 1'b1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  // Without statistics, CNT_W only sizes ports that are not built.
  if (CNT_W > 0) begin : g_stats_off
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_controller
// Purpose  : Directed bench for cache_controller. It contains a small
//            behavioural direct-mapped cache and a scripted memory
//            acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller;
  localparam int TAG_W    = 24;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 2;
  localparam int CNT_W    = 32;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic                              cpu_valid = 1'b0;
  logic                              cpu_req_type = 1'b0;
  logic [TAG_W+INDEX_W+OFFSET_W-1:0] cpu_addr = '0;
  logic                              mem_ready = 1'b0;
  logic [31:0]                       cpu_wdata = '0;
  logic                              cpu_done, cpu_busy, req_type;
  logic [TAG_W-1:0]                  tag;
  logic [INDEX_W-1:0]                index;
  logic [OFFSET_W-1:0]               blk_offset;
  logic                              read_en_cache, write_en_cache, ready_mem;
  logic                              hit, dirty_bit;
  logic [TAG_W-1:0]                  victim_tag;
  logic                              mem_rd_req, mem_wr_req;
  logic [TAG_W+INDEX_W-1:0]          mem_addr;
`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0]                  hit_count, miss_count, wb_count;
`endif

  cache_controller #(
    .TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_req_type(cpu_req_type),
    .cpu_addr(cpu_addr), .cpu_done(cpu_done), .cpu_busy(cpu_busy), .tag(tag),
    .index(index), .blk_offset(blk_offset), .req_type(req_type),
    .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .ready_mem(ready_mem), .hit(hit), .dirty_bit(dirty_bit),
    .victim_tag(victim_tag), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural cache array: refilled blocks hold {2'b00, block address} in every word.
  logic [127:0]     c_data  [64];
  logic [TAG_W-1:0] c_tag   [64];
  logic             c_valid [64];
  logic             c_dirty [64];
  logic [31:0]      data_out;
  logic [127:0]     dirty_block_out;

  assign hit             = c_valid[index] && (c_tag[index] == tag);
  assign dirty_bit       = c_dirty[index];
  assign victim_tag      = c_tag[index];
  assign data_out        = c_data[index][{blk_offset, 5'b0} +: 32];
  assign dirty_block_out = c_data[index];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        c_valid[i] <= 1'b0;
        c_dirty[i] <= 1'b0;
        c_tag[i]   <= '0;
        c_data[i]  <= '0;
      end
    end else if (write_en_cache && ready_mem) begin
      c_data[index]  <= {4{2'b00, mem_addr}};
      c_tag[index]   <= tag;
      c_valid[index] <= 1'b1;
      c_dirty[index] <= 1'b0;
    end else if (read_en_cache && write_en_cache && hit) begin
      c_data[index][{blk_offset, 5'b0} +: 32] <= cpu_wdata;
      c_dirty[index] <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk_b(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic v, input logic wr, input logic [TAG_W-1:0] t,
                     input logic [INDEX_W-1:0] i, input logic [OFFSET_W-1:0] o);
    cpu_valid    = v;
    cpu_req_type = wr;
    cpu_addr     = {t, i, o};
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    #1;
    chk_b("rst_done", cpu_done, 1'b0);
    chk_b("rst_busy", cpu_busy, 1'b0);
    chk_w("rst_tag", 32'(tag), 32'h0);
    chk_b("rst_rd_en", read_en_cache, 1'b0);
    chk_b("rst_mem_rd", mem_rd_req, 1'b0);
    chk_b("rst_mem_wr", mem_wr_req, 1'b0);
    rst_n = 1'b1;

    // Cold read miss on index 4, tag 0; memory acks in the third ALLOCATE cycle
    step(); req(1'b1, 1'b0, 24'd0, 6'h04, 2'd0); #1;
    chk_b("t1_idle_busy", cpu_busy, 1'b0);
    step(); #1;
    chk_b("t1_cmp_rd_en", read_en_cache, 1'b1);
    chk_b("t1_cmp_wr_en", write_en_cache, 1'b0);
    chk_b("t1_cmp_busy", cpu_busy, 1'b1);
    chk_w("t1_cmp_index", 32'(index), 32'h4);
    step(); #1;
    chk_b("t1_alloc_rdreq", mem_rd_req, 1'b1);
    chk_b("t1_alloc_wrreq", mem_wr_req, 1'b0);
    chk_w("t1_alloc_addr", 32'(mem_addr), 32'h004);
    chk_b("t1_alloc_wait_wren", write_en_cache, 1'b0);
    step(); #1;
    chk_b("t1_alloc_rdreq2", mem_rd_req, 1'b1);
    step(); mem_ready = 1'b1; #1;
    chk_b("t1_fill_wren", write_en_cache, 1'b1);
    chk_b("t1_fill_ready", ready_mem, 1'b1);
    step(); mem_ready = 1'b0; #1;
    chk_b("t1_replay_rd_en", read_en_cache, 1'b1);
    chk_b("t1_replay_done", cpu_done, 1'b0);
    step(); #1;
    chk_b("t1_done", cpu_done, 1'b1);
    chk_b("t1_done_busy", cpu_busy, 1'b1);
    chk_w("t1_data", data_out, 32'h4);
    cpu_valid = 1'b0;
    step(); #1;
    chk_b("t1_done_pulse", cpu_done, 1'b0);
    chk_b("t1_post_busy", cpu_busy, 1'b0);

    // Same read again: hit with done two cycles after accept
    step(); req(1'b1, 1'b0, 24'd0, 6'h04, 2'd0); #1;
    step(); #1;
    chk_b("t2_cmp_rd_en", read_en_cache, 1'b1);
    chk_b("t2_cmp_no_mem", mem_rd_req, 1'b0);
    chk_b("t2_cmp_done", cpu_done, 1'b0);
    step(); #1;
    chk_b("t2_done", cpu_done, 1'b1);
    chk_w("t2_data", data_out, 32'h4);
    chk_b("t2_no_mem", mem_rd_req, 1'b0);
    cpu_valid = 1'b0;

    // Write hit, then a conflicting read that is issued during the done cycle
    step(); req(1'b1, 1'b1, 24'd0, 6'h04, 2'd0); cpu_wdata = 32'hDEADBEEF; #1;
    step(); #1;
    chk_b("t3_wr_wren", write_en_cache, 1'b1);
    chk_b("t3_wr_rden", read_en_cache, 1'b1);
    step(); #1;
    chk_b("t3_wr_done", cpu_done, 1'b1);
    req(1'b1, 1'b0, 24'd1, 6'h04, 2'd0);
    step(); #1;
    chk_b("t3_turnaround_busy", cpu_busy, 1'b0);
    chk_b("t3_turnaround_rden", read_en_cache, 1'b0);
    step(); #1;
    chk_b("t3_cmp_rd_en", read_en_cache, 1'b1);
    chk_b("t3_cmp_wrreq", mem_wr_req, 1'b0);
    step(); #1;
    chk_b("t3_wb_wrreq", mem_wr_req, 1'b1);
    chk_b("t3_wb_rdreq", mem_rd_req, 1'b0);
    chk_w("t3_wb_addr", 32'(mem_addr), 32'h004);
    chk_w("t3_wb_data", dirty_block_out[31:0], 32'hDEADBEEF);
    step(); mem_ready = 1'b1; #1;
    chk_b("t3_wb_ack_wrreq", mem_wr_req, 1'b1);
    chk_b("t3_wb_ack_wren", write_en_cache, 1'b0);
    step(); mem_ready = 1'b0; #1;
    chk_b("t3_alloc_rdreq", mem_rd_req, 1'b1);
    chk_b("t3_alloc_wrreq", mem_wr_req, 1'b0);
    chk_w("t3_alloc_addr", 32'(mem_addr), 32'h044);
    step(); mem_ready = 1'b1; #1;
    chk_b("t3_fill_wren", write_en_cache, 1'b1);
    chk_b("t3_fill_ready", ready_mem, 1'b1);
    step(); mem_ready = 1'b0; #1;
    chk_b("t3_replay_rd_en", read_en_cache, 1'b1);
    chk_b("t3_replay_wren", write_en_cache, 1'b0);
    step(); #1;
    chk_b("t3_done", cpu_done, 1'b1);
    chk_w("t3_data", data_out, 32'h44);
    cpu_valid = 1'b0;
`ifdef CACHE_STATS_EN
    chk_w("stat_hits", hit_count, 32'd2);
    chk_w("stat_misses", miss_count, 32'd2);
    chk_w("stat_wbs", wb_count, 32'd1);
`endif

    // Dirty miss with mem_ready held high throughout
    step(); req(1'b1, 1'b1, 24'd1, 6'h04, 2'd0); cpu_wdata = 32'h12345678; #1;
    step(); #1;
    chk_b("t4_wr_wren", write_en_cache, 1'b1);
    step(); #1;
    chk_b("t4_wr_done", cpu_done, 1'b1);
    cpu_valid = 1'b0;
    mem_ready = 1'b1;
    step(); req(1'b1, 1'b0, 24'd2, 6'h04, 2'd0); #1;
    chk_b("t4_idle_rdreq", mem_rd_req, 1'b0);
    chk_b("t4_idle_wrreq", mem_wr_req, 1'b0);
    chk_b("t4_idle_wren", write_en_cache, 1'b0);
    step(); #1;
    chk_b("t4_cmp_rd_en", read_en_cache, 1'b1);
    chk_b("t4_cmp_ready", ready_mem, 1'b0);
    chk_b("t4_cmp_wrreq", mem_wr_req, 1'b0);
    step(); #1;
    chk_b("t4_wb_wrreq", mem_wr_req, 1'b1);
    chk_b("t4_wb_rdreq", mem_rd_req, 1'b0);
    chk_w("t4_wb_addr", 32'(mem_addr), 32'h044);
    chk_w("t4_wb_data", dirty_block_out[31:0], 32'h12345678);
    step(); #1;
    chk_b("t4_alloc_rdreq", mem_rd_req, 1'b1);
    chk_b("t4_alloc_wrreq", mem_wr_req, 1'b0);
    chk_b("t4_alloc_wren", write_en_cache, 1'b1);
    chk_w("t4_alloc_addr", 32'(mem_addr), 32'h084);
    step(); #1;
    chk_b("t4_replay_rd_en", read_en_cache, 1'b1);
    chk_b("t4_replay_rdreq", mem_rd_req, 1'b0);
    chk_b("t4_replay_ready", ready_mem, 1'b0);
    step(); #1;
    chk_b("t4_done", cpu_done, 1'b1);
    chk_w("t4_data", data_out, 32'h84);
    cpu_valid = 1'b0;
    mem_ready = 1'b0;

    // Reset asserted while in ALLOCATE
    step(); req(1'b1, 1'b0, 24'd3, 6'h04, 2'd0); #1;
    step(); #1;
    chk_b("t5_cmp_rd_en", read_en_cache, 1'b1);
    step(); #1;
    chk_b("t5_alloc_rdreq", mem_rd_req, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk_b("t5_async_rdreq", mem_rd_req, 1'b0);
    chk_b("t5_async_busy", cpu_busy, 1'b0);
    chk_b("t5_async_done", cpu_done, 1'b0);
    cpu_valid = 1'b0;
    step(); #1;
    chk_b("t5_rst_done", cpu_done, 1'b0);
    chk_w("t5_rst_tag", 32'(tag), 32'h0);
    rst_n = 1'b1;
    step(); #1;
    chk_b("t5_post_done", cpu_done, 1'b0);
    chk_b("t5_post_busy", cpu_busy, 1'b0);
    chk_b("t5_post_rdreq", mem_rd_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
